// File: rtl/exec_debug_ctrl.sv
// Debug/execution controller: gates the pipeline for RUN/STEP and streams a
// PC / cycle-count / register-file / data-memory dump over a valid-ready port.
module exec_debug_ctrl #(
   parameter int NBITS     = 32,
   parameter int RBITS     = 5,
   parameter int BANK_SIZE = 32,
   parameter int MEM_SIZE  = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_cmd_valid,
   input  logic [1:0]          i_cmd,
   output logic                o_cmd_ready,
   input  logic                i_halt,
   input  logic [NBITS-1:0]    i_pc,
   output logic                o_pipe_en,
   output logic [RBITS-1:0]    o_rf_addr,
   input  logic [NBITS-1:0]    i_rf_data,
   output logic [MEM_SIZE-1:0] o_mem_addr,
   input  logic [NBITS-1:0]    i_mem_data,
   output logic [NBITS-1:0]    o_tx_data,
   output logic                o_tx_valid,
   input  logic                i_tx_ready,
   output logic [NBITS-1:0]    o_cycle_cnt,
   output logic                o_halted
);

   typedef enum logic [1:0] {CMD_NOP, CMD_RUN, CMD_STEP, CMD_DUMP} cmd_t;

   typedef enum logic [2:0] {
      IDLE, RUN, STEP, DUMP_PC, DUMP_CYC, DUMP_REG, DUMP_MEM
   } state_t;

   localparam logic [RBITS-1:0]    RF_LAST  = RBITS'(BANK_SIZE - 1);
   localparam logic [MEM_SIZE-1:0] MEM_LAST = '1;

   state_t                state, state_nxt;
   logic [RBITS-1:0]      rf_addr_nxt;
   logic [MEM_SIZE-1:0]   mem_addr_nxt;
   logic                  accept;
   logic                  xfer;

   assign o_cmd_ready = (state == IDLE);
   assign o_tx_valid  = (state == DUMP_PC) || (state == DUMP_CYC) ||
                        (state == DUMP_REG) || (state == DUMP_MEM);
   assign accept      = o_cmd_ready & i_cmd_valid;
   assign xfer        = o_tx_valid & i_tx_ready;

   // NOTE: every signal written here gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_nxt    = state;
      rf_addr_nxt  = o_rf_addr;
      mem_addr_nxt = o_mem_addr;
      unique case (state)
         IDLE: begin
            if (accept) begin
               case (cmd_t'(i_cmd))
                  CMD_NOP:  state_nxt = IDLE;
                  CMD_RUN:  if (!o_halted) state_nxt = RUN;
                  CMD_STEP: if (!o_halted) state_nxt = STEP;
                  CMD_DUMP: begin
                     state_nxt    = DUMP_PC;
                     rf_addr_nxt  = '0;
                     mem_addr_nxt = '0;
                  end
               endcase
            end
         end
         RUN:      if (i_halt) state_nxt = IDLE;
         STEP:     state_nxt = IDLE;
         DUMP_PC:  if (xfer) state_nxt = DUMP_CYC;
         DUMP_CYC: if (xfer) state_nxt = DUMP_REG;
         DUMP_REG: begin
            if (xfer) begin
               if (o_rf_addr == RF_LAST) begin
                  rf_addr_nxt = '0;
                  state_nxt   = DUMP_MEM;
               end else begin
                  rf_addr_nxt = o_rf_addr + RBITS'(1);
               end
            end
         end
         DUMP_MEM: begin
            if (xfer) begin
               if (o_mem_addr == MEM_LAST) begin
                  mem_addr_nxt = '0;
                  state_nxt    = IDLE;
               end else begin
                  mem_addr_nxt = o_mem_addr + MEM_SIZE'(1);
               end
            end
         end
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_tx_data = '0;
      case (state)
         DUMP_PC:  o_tx_data = i_pc;
         DUMP_CYC: o_tx_data = o_cycle_cnt;
         DUMP_REG: o_tx_data = i_rf_data;
         DUMP_MEM: o_tx_data = i_mem_data;
         default:  o_tx_data = '0;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         o_pipe_en   <= 1'b0;
         o_rf_addr   <= '0;
         o_mem_addr  <= '0;
         o_cycle_cnt <= '0;
         o_halted    <= 1'b0;
      end else begin
         state      <= state_nxt;
         o_pipe_en  <= (state_nxt == RUN) || (state_nxt == STEP);
         o_rf_addr  <= rf_addr_nxt;
         o_mem_addr <= mem_addr_nxt;
         if (o_pipe_en) begin
            o_cycle_cnt <= o_cycle_cnt + NBITS'(1);
            if (i_halt) o_halted <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_exec_debug_ctrl.sv
// Directed bench for exec_debug_ctrl: a table of RUN/STEP/NOP vectors plus
// hand-written dump, back-pressure and mid-operation reset sequences.
module tb_exec_debug_ctrl;

   localparam int NBITS   = 32;
   localparam int RBITS   = 5;
   localparam int MEMW    = 5;
   localparam int NWORDS  = 2 + 32 + 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_cmd_valid;
   logic [1:0]        i_cmd;
   logic              o_cmd_ready;
   logic              i_halt;
   logic [NBITS-1:0]  i_pc;
   logic              o_pipe_en;
   logic [RBITS-1:0]  o_rf_addr;
   logic [NBITS-1:0]  i_rf_data;
   logic [MEMW-1:0]   o_mem_addr;
   logic [NBITS-1:0]  i_mem_data;
   logic [NBITS-1:0]  o_tx_data;
   logic              o_tx_valid;
   logic              i_tx_ready;
   logic [NBITS-1:0]  o_cycle_cnt;
   logic              o_halted;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Register file holds rf[k]=k, data memory holds mem[k]=0x100+k.
   assign i_rf_data  = NBITS'(o_rf_addr);
   assign i_mem_data = 32'h100 + NBITS'(o_mem_addr);

   exec_debug_ctrl #(.NBITS(NBITS), .RBITS(RBITS), .BANK_SIZE(32), .MEM_SIZE(MEMW)) dut (
      .clk(clk), .rst(rst),
      .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .o_cmd_ready(o_cmd_ready),
      .i_halt(i_halt), .i_pc(i_pc), .o_pipe_en(o_pipe_en),
      .o_rf_addr(o_rf_addr), .i_rf_data(i_rf_data),
      .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
      .o_cycle_cnt(o_cycle_cnt), .o_halted(o_halted)
   );

   typedef struct {
      bit          rst_first;
      logic [1:0]  cmd;
      int          halt_at;     // enabled cycle on which i_halt pulses, 0 = never
      bit          halt_idle;   // drive i_halt while the pipeline is disabled
      int          exp_pulses;
      logic [31:0] exp_cnt;
      bit          exp_halted;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic issue(input logic [1:0] c);
      check("ready_before_cmd", o_cmd_ready, 1);
      i_cmd_valid = 1'b1;
      i_cmd       = c;
      @(negedge clk);
      i_cmd_valid = 1'b0;
      i_cmd       = 2'b00;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int en = 0;
      if (v.rst_first) do_reset();
      issue(v.cmd);
      for (int i = 0; i < 16; i++) begin
         if (o_pipe_en) begin
            en++;
            i_halt = (en == v.halt_at);
         end else begin
            i_halt = v.halt_idle;
         end
         @(negedge clk);
      end
      i_halt = 1'b0;
      check($sformatf("v%0d_pulses", idx), en, v.exp_pulses);
      check($sformatf("v%0d_cnt", idx), o_cycle_cnt, v.exp_cnt);
      check($sformatf("v%0d_halted", idx), o_halted, v.exp_halted);
      check($sformatf("v%0d_ready", idx), o_cmd_ready, 1);
   endtask

   task automatic do_dump(input bit toggle, input logic [31:0] exp_cnt, input bit exp_halted);
      logic [31:0] exp_w[NWORDS];
      logic [31:0] held = '0;
      bit          holding = 1'b0;
      bit          rdy;
      int          got = 0;
      int          valid_cycles = 0;
      exp_w[0] = 32'h40;
      exp_w[1] = exp_cnt;
      for (int k = 0; k < 32; k++) exp_w[2 + k]  = k;
      for (int k = 0; k < 32; k++) exp_w[34 + k] = 32'h100 + k;
      issue(2'b11);
      for (int cyc = 0; cyc < 400 && got < NWORDS; cyc++) begin
         if (holding) begin
            check("hold_valid", o_tx_valid, 1);
            check("hold_data", o_tx_data, held);
            holding = 1'b0;
         end
         rdy = toggle ? (cyc % 2 == 0) : 1'b1;
         i_tx_ready = rdy;
         if (o_tx_valid) begin
            valid_cycles++;
            if (rdy) begin
               check($sformatf("word%0d", got), o_tx_data, exp_w[got]);
               got++;
            end else begin
               held    = o_tx_data;
               holding = 1'b1;
            end
         end
         @(negedge clk);
      end
      i_tx_ready = 1'b0;
      check("dump_words", got, NWORDS);
      if (!toggle) check("dump_cycles", valid_cycles, NWORDS);
      check("dump_end_valid", o_tx_valid, 0);
      check("dump_end_ready", o_cmd_ready, 1);
      check("dump_end_rf_addr", o_rf_addr, 0);
      check("dump_end_mem_addr", o_mem_addr, 0);
      check("dump_cnt_kept", o_cycle_cnt, exp_cnt);
      check("dump_halted_kept", o_halted, exp_halted);
   endtask

   initial begin
      vecs[0] = '{1'b1, 2'b10, 1, 1'b0, 1, 32'd1, 1'b1};   // STEP with halt
      vecs[1] = '{1'b1, 2'b01, 1, 1'b0, 1, 32'd1, 1'b1};   // RUN halting at once
      vecs[2] = '{1'b1, 2'b10, 0, 1'b0, 1, 32'd1, 1'b0};   // STEP x3
      vecs[3] = '{1'b0, 2'b10, 0, 1'b0, 1, 32'd2, 1'b0};
      vecs[4] = '{1'b0, 2'b10, 0, 1'b0, 1, 32'd3, 1'b0};
      vecs[5] = '{1'b0, 2'b00, 0, 1'b1, 0, 32'd3, 1'b0};   // NOP, halt while idle ignored
      vecs[6] = '{1'b1, 2'b01, 10, 1'b0, 10, 32'd10, 1'b1}; // RUN, halt at 10th
      vecs[7] = '{1'b0, 2'b01, 0, 1'b0, 0, 32'd10, 1'b1};  // RUN after halt
      vecs[8] = '{1'b0, 2'b10, 0, 1'b0, 0, 32'd10, 1'b1};  // STEP after halt

      rst = 1'b1; i_cmd_valid = 1'b0; i_cmd = 2'b00; i_halt = 1'b0;
      i_pc = 32'h40; i_tx_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pipe_en", o_pipe_en, 0);
      check("rst_tx_valid", o_tx_valid, 0);
      check("rst_cnt", o_cycle_cnt, 0);
      check("rst_halted", o_halted, 0);
      check("rst_rf_addr", o_rf_addr, 0);
      check("rst_mem_addr", o_mem_addr, 0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_release", o_cmd_ready, 1);

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      do_dump(1'b0, 32'd10, 1'b1);
      do_dump(1'b1, 32'd10, 1'b1);

      // Reset in the middle of the register dump.
      do_reset();
      issue(2'b10);
      @(negedge clk);
      issue(2'b11);
      i_tx_ready = 1'b1;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (o_tx_valid && o_rf_addr == 5'd7) break;
         @(negedge clk);
      end
      check("mid_dump_rf_addr", o_rf_addr, 7);
      rst = 1'b1;
      @(negedge clk);
      check("mid_dump_rst_valid", o_tx_valid, 0);
      check("mid_dump_rst_ready", o_cmd_ready, 1);
      check("mid_dump_rst_rf_addr", o_rf_addr, 0);
      check("mid_dump_rst_cnt", o_cycle_cnt, 0);
      rst = 1'b0;
      i_tx_ready = 1'b0;
      @(negedge clk);
      check("mid_dump_ready_after", o_cmd_ready, 1);

      // Reset in the middle of an unbounded RUN.
      issue(2'b01);
      repeat (5) @(negedge clk);
      check("mid_run_pipe_en", o_pipe_en, 1);
      check("mid_run_cnt", o_cycle_cnt, 5);
      rst = 1'b1;
      @(negedge clk);
      check("mid_run_rst_pipe_en", o_pipe_en, 0);
      check("mid_run_rst_cnt", o_cycle_cnt, 0);
      check("mid_run_rst_ready", o_cmd_ready, 1);
      rst = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exec_debug_ctrl.md
EXEC_DEBUG_CTRL -- requirements
Module: exec_debug_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 32, data word width.
REQ-002 SHALL have parameter RBITS, default 5, register-file address width.
REQ-003 SHALL have parameter BANK_SIZE, default 32, number of registers dumped.
REQ-004 SHALL have parameter MEM_SIZE, default 5, data-memory address width; words dumped = 2**MEM_SIZE.
REQ-005 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command offered.
- i_cmd  in  2  00 NOP, 01 RUN, 10 STEP, 11 DUMP.
- o_cmd_ready  out  1  command accepted when valid&ready.
- i_halt  in  1  datapath retired HALT this cycle.
- i_pc  in  NBITS  current PC.
- o_pipe_en  out  1  global pipeline enable.
- o_rf_addr  out  RBITS  register-file read address.
- i_rf_data  in  NBITS  register-file read data, asynchronous read.
- o_mem_addr  out  MEM_SIZE  data-memory read address.
- i_mem_data  in  NBITS  data-memory read data, asynchronous read.
- o_tx_data  out  NBITS  dump word.
- o_tx_valid  out  1  dump word valid.
- i_tx_ready  in  1  sink accepts word.
- o_cycle_cnt  out  NBITS  enabled-cycle counter.
- o_halted  out  1  program finished.

Function
REQ-006 SHALL implement FSM states IDLE, RUN, STEP, DUMP_PC, DUMP_CYC, DUMP_REG, DUMP_MEM.
REQ-007 o_cmd_ready SHALL be 1 only in IDLE; commands in other states are neither accepted nor queued.
REQ-008 IDLE accept: NOP -> stay IDLE; RUN -> RUN; STEP -> STEP; DUMP -> DUMP_PC with o_rf_addr=0 and o_mem_addr=0.
REQ-009 RUN or STEP accepted while o_halted=1 SHALL leave state IDLE and o_pipe_en 0.
REQ-010 o_pipe_en SHALL be 1 exactly in cycles where state is RUN or STEP; registered, no combinational path from i_cmd.
REQ-011 o_cycle_cnt SHALL increment by 1 in every cycle with o_pipe_en=1, wrapping modulo 2**NBITS.
REQ-012 RUN: stays until i_halt=1 while o_pipe_en=1; that cycle counts, o_halted set to 1, next state IDLE.
REQ-013 STEP: exactly one cycle of o_pipe_en=1, then IDLE; i_halt=1 in that cycle sets o_halted.
REQ-014 i_halt SHALL be ignored when o_pipe_en=0.
REQ-015 DUMP states: o_tx_valid=1; word transfers on o_tx_valid & i_tx_ready; o_tx_data and addresses held stable until transfer.
REQ-016 Dump order: DUMP_PC o_tx_data=i_pc; DUMP_CYC o_tx_data=o_cycle_cnt; DUMP_REG o_tx_data=i_rf_data for o_rf_addr 0..BANK_SIZE-1; DUMP_MEM o_tx_data=i_mem_data for o_mem_addr 0..2**MEM_SIZE-1.
REQ-017 In DUMP_REG/DUMP_MEM, address SHALL increment by 1 per transfer; transfer at last address moves to next state (DUMP_MEM last -> IDLE) with that address returned to 0.
REQ-018 Outside DUMP states o_tx_valid SHALL be 0; o_tx_data is don't-care.
REQ-019 A full dump SHALL be 2+BANK_SIZE+2**MEM_SIZE transfers (66 with defaults); minimum duration equals that many cycles with i_tx_ready held 1.
REQ-020 DUMP SHALL NOT modify o_cycle_cnt or o_halted.

Reset
REQ-021 rst=1 at a rising edge SHALL force state IDLE, o_pipe_en=0, o_tx_valid=0, o_cycle_cnt=0, o_halted=0, o_rf_addr=0, o_mem_addr=0, in any state including mid-RUN and mid-dump.
REQ-022 The first cycle after reset release SHALL show o_cmd_ready=1.

Verification
REQ-023 Reset then STEP x3 (halt never asserted) -> three isolated single-cycle o_pipe_en pulses, o_cycle_cnt=3, o_halted=0.
REQ-024 RUN with i_halt pulsed at 10th enabled cycle -> o_pipe_en high exactly 10 cycles, o_cycle_cnt=10, o_halted=1, o_cmd_ready=1 next cycle.
REQ-025 After halt, RUN then STEP -> both accepted, o_pipe_en stays 0, o_cycle_cnt unchanged.
REQ-026 DUMP, i_tx_ready=1, i_pc=0x40, rf[k]=k, mem[k]=0x100+k -> 66 words: 0x40, cycle count, 0..31, 0x100..0x11F, then IDLE.
REQ-027 DUMP with i_tx_ready toggling 1/0 each cycle -> each word held while ready=0, same 66-word sequence, no duplicates or drops.
REQ-028 rst asserted during DUMP_REG at o_rf_addr=7 -> next cycle o_tx_valid=0, state IDLE, o_rf_addr=0, o_cycle_cnt=0.
